vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Parametrised successor to the fixed 640x480 VGA sync generator.
- Produces HS, VS, blank_n and active-area pixel coordinates for any timing set, with programmable sync polarity and a pixel-clock enable.
- Adds a configurable output delay line to match pixel-generator pipeline latency, plus frame/line/vblank event pulses and a frame counter (used for sprite blink/animation timing).
- Sits between the pixel clock domain root and the game drawing logic.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FRONT, 11, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BACK, 32, vertical back porch (lines)
HS_POL, 0, active level of HS during sync (0 = active-low)
VS_POL, 0, active level of VS during sync
PIPE_LAT, 0, extra vga_clk cycles of delay on HS/VS/blank_n (0..15)
COORD_W, 11, width of pixelX/pixelY
FRAME_W, 8, width of frame_cnt

Ports:
vga_clk  in  1  pixel clock, all logic on rising edge
reset  in  1  synchronous, active-high
pix_ce  in  1  pixel advance enable; tie high for one pixel per clock
HS  out  1  horizontal sync, polarity HS_POL, delayed PIPE_LAT
VS  out  1  vertical sync, polarity VS_POL, delayed PIPE_LAT
blank_n  out  1  high in visible area, delayed PIPE_LAT
pixelX  out  COORD_W  active-area column, 0 outside visible area
pixelY  out  COORD_W  active-area row, 0 outside visible area
line_start  out  1  one-clock pulse at first visible pixel of each visible line
frame_start  out  1  one-clock pulse at pixel (0,0)
vblank_start  out  1  one-clock pulse at first pixel of first vertical front-porch line
frame_cnt  out  FRAME_W  completed-frame counter, wraps modulo 2^FRAME_W

Behaviour:
- H_TOTAL = H_SYNC+H_BACK+H_ACTIVE+H_FRONT; V_TOTAL likewise. Region order within a line/frame: sync, back porch, active, front porch.
- Counters h_cnt and v_cnt start at 0 and advance only on edges with pix_ce=1.
  - h_cnt == H_TOTAL-1: h_cnt wraps to 0 and v_cnt increments.
  - v_cnt == V_TOTAL-1 at h wrap: v_cnt wraps to 0 and frame_cnt increments.
- Decode from the current counters:
  - hsync = h_cnt < H_SYNC; vsync = v_cnt < V_SYNC.
  - h_act = H_SYNC+H_BACK <= h_cnt < H_TOTAL-H_FRONT; v_act analogous.
- Stage 0 registers capture the decode on every vga_clk edge:
  - pixelX = h_act&&v_act ? h_cnt-(H_SYNC+H_BACK) : 0; pixelY analogous.
  - Pulses = decode condition AND pix_ce, so each pulse is exactly one vga_clk wide even when pix_ce is divided.
- Latency:
  - pixelX/pixelY/pulses/frame_cnt: 1 clock after the counter value.
  - HS/VS/blank_n: 1+PIPE_LAT clocks; the delay line shifts every vga_clk regardless of pix_ce.
- HS = hsync ? HS_POL : !HS_POL; VS analogous.
- Coordinate widths: subtraction done in COORD_W bits. The generator never produces a negative or out-of-range coordinate; the visible area alone ranges 0..H_ACTIVE-1 / 0..V_ACTIVE-1.
- Reset (synchronous, any time incl. mid-line), effective the clock after reset is sampled high:
  - Counters and frame_cnt = 0; all delay-line stages flushed.
  - HS = !HS_POL, VS = !VS_POL; blank_n, pulses, pixelX, pixelY = 0.
  - While reset is held, the counters stay at 0.
  - First post-reset counter state (0,0) is in sync, so HS/VS assert 1+PIPE_LAT clocks after release.
- pix_ce low for any duration: counters freeze, stage outputs hold, pulses stay 0, no event is lost or repeated.
- frame_start and line_start fire together at (0,0). vblank_start never coincides with them.

Test Plan:
- Defaults, pix_ce=1, release reset -> HS low 96 clocks then high 704; line period 800 clocks; frame period 420000 clocks; VS low for exactly 1600 clocks.
- Defaults -> blank_n first high in line 34 at h=144 with pixelX=0,pixelY=0 and frame_start=1; pixelX=639 at h=783, then blank_n=0, pixelX=0; last visible line pixelY=479 (v=513); vblank_start at v=514,h=0.
- FRAME_W=8, run 257 frames -> frame_cnt sequence ...,254,255,0,1; increments exactly at v wrap.
- pix_ce toggling 1,0,1,0 -> line period 1600 clocks, frame_start/line_start still one clock wide, pixelX held constant across ce-low clocks.
- PIPE_LAT=3, HS_POL=1, VS_POL=1 -> HS/VS/blank_n identical to baseline shifted by exactly 3 clocks and HS/VS inverted; pixelX/pixelY unshifted; HS=0 during reset.
- Assert reset one clock at h=500,v=200 -> next clock all outputs at reset values; after release, timing restarts from (0,0) with no residual pulses from the flushed delay line.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: sync/blank/coordinates, event pulses and a
// frame counter, with an optional delay line on HS/VS/blank_n for pipeline matching.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 11,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 32,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int PIPE_LAT = 0,
  parameter int COORD_W  = 11,
  parameter int FRAME_W  = 8
) (
  input  logic               vga_clk,
  input  logic               reset,
  input  logic               pix_ce,
  output logic               HS,
  output logic               VS,
  output logic               blank_n,
  output logic [COORD_W-1:0] pixelX,
  output logic [COORD_W-1:0] pixelY,
  output logic               line_start,
  output logic               frame_start,
  output logic               vblank_start,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

  localparam logic [COORD_W-1:0] H_LAST      = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST      = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_SYNC_END  = COORD_W'(H_SYNC);
  localparam logic [COORD_W-1:0] V_SYNC_END  = COORD_W'(V_SYNC);
  localparam logic [COORD_W-1:0] H_ACT_START = COORD_W'(H_SYNC + H_BACK);
  localparam logic [COORD_W-1:0] V_ACT_START = COORD_W'(V_SYNC + V_BACK);
  localparam logic [COORD_W-1:0] H_ACT_END   = COORD_W'(H_TOTAL - H_FRONT);
  localparam logic [COORD_W-1:0] V_ACT_END   = COORD_W'(V_TOTAL - V_FRONT);
  localparam logic [COORD_W-1:0] V_VBLANK    = COORD_W'(V_SYNC + V_BACK + V_ACTIVE);

  localparam logic HS_ACT = (HS_POL != 0);
  localparam logic VS_ACT = (VS_POL != 0);

  logic [COORD_W-1:0] h_cnt;
  logic [COORD_W-1:0] v_cnt;
  logic [FRAME_W-1:0] frame_q;

  // Raster counters; everything freezes while pix_ce is low.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      h_cnt   <= '0;
      v_cnt   <= '0;
      frame_q <= '0;
    end else if (pix_ce) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        if (v_cnt == V_LAST) begin
          v_cnt   <= '0;
          frame_q <= frame_q + 1'b1;
        end else begin
          v_cnt <= v_cnt + 1'b1;
        end
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  logic               hsync_d;
  logic               vsync_d;
  logic               h_act;
  logic               v_act;
  logic               vis_d;
  logic [COORD_W-1:0] px_d;
  logic [COORD_W-1:0] py_d;
  logic               line_start_d;
  logic               frame_start_d;
  logic               vblank_start_d;

  always_comb begin
    hsync_d        = (h_cnt < H_SYNC_END);
    vsync_d        = (v_cnt < V_SYNC_END);
    h_act          = (h_cnt >= H_ACT_START) && (h_cnt < H_ACT_END);
    v_act          = (v_cnt >= V_ACT_START) && (v_cnt < V_ACT_END);
    vis_d          = h_act && v_act;
    px_d           = '0;
    py_d           = '0;
    if (vis_d) begin
      px_d = h_cnt - H_ACT_START;
      py_d = v_cnt - V_ACT_START;
    end
    // Gating with pix_ce keeps each pulse one clock wide under a divided enable.
    line_start_d   = pix_ce && vis_d && (h_cnt == H_ACT_START);
    frame_start_d  = line_start_d && (v_cnt == V_ACT_START);
    vblank_start_d = pix_ce && (h_cnt == '0) && (v_cnt == V_VBLANK);
  end

  // Stage 0: bit order {hsync, vsync, visible}, stored as "active" flags.
  logic [2:0] sync_s0;

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      sync_s0      <= '0;
      pixelX       <= '0;
      pixelY       <= '0;
      line_start   <= 1'b0;
      frame_start  <= 1'b0;
      vblank_start <= 1'b0;
      frame_cnt    <= '0;
    end else begin
      sync_s0      <= {hsync_d, vsync_d, vis_d};
      pixelX       <= px_d;
      pixelY       <= py_d;
      line_start   <= line_start_d;
      frame_start  <= frame_start_d;
      vblank_start <= vblank_start_d;
      frame_cnt    <= frame_q;
    end
  end

  logic [2:0] sync_tail;

  generate
    if (PIPE_LAT == 0) begin : g_no_delay
      assign sync_tail = sync_s0;
    end else begin : g_delay
      logic [2:0] dly [PIPE_LAT];

      // Shifts every clock independent of pix_ce so latency is in vga_clk cycles.
      always_ff @(posedge vga_clk) begin
        if (reset) begin
          for (int i = 0; i < PIPE_LAT; i++) dly[i] <= '0;
        end else begin
          dly[0] <= sync_s0;
          for (int i = 1; i < PIPE_LAT; i++) dly[i] <= dly[i-1];
        end
      end

      assign sync_tail = dly[PIPE_LAT-1];
    end
  endgenerate

  assign HS      = sync_tail[2] ? HS_ACT : !HS_ACT;
  assign VS      = sync_tail[1] ? VS_ACT : !VS_ACT;
  assign blank_n = sync_tail[0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a reduced raster (15x9): a per-cycle scoreboard fed by a
// reference model, a hand-computed probe table, and timing/reset/wrap sequences.
module tb_vga_timing_gen;

  localparam int HSY = 3, HBK = 2, HACT = 8, HFP = 2, HT = HSY + HBK + HACT + HFP;
  localparam int VSY = 2, VBK = 2, VACT = 4, VFP = 1, VT = VSY + VBK + VACT + VFP;
  localparam int FT  = HT * VT;
  localparam int EW  = 3 + 11 + 11 + 3 + 8 + 3;

  logic        vga_clk = 1'b0;
  logic        reset   = 1'b1;
  logic        pix_ce  = 1'b0;
  logic        HS, VS, blank_n, line_start, frame_start, vblank_start;
  logic [10:0] pixelX, pixelY;
  logic [7:0]  frame_cnt;
  logic        HS2, VS2, blank2, ls2, fs2, vbs2;
  logic [10:0] px2, py2;
  logic [7:0]  fc2;

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];

  // clock / reset block
  always #5 vga_clk = ~vga_clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  vga_timing_gen #(
    .H_ACTIVE(HACT), .H_FRONT(HFP), .H_SYNC(HSY), .H_BACK(HBK),
    .V_ACTIVE(VACT), .V_FRONT(VFP), .V_SYNC(VSY), .V_BACK(VBK),
    .HS_POL(0), .VS_POL(0), .PIPE_LAT(0), .COORD_W(11), .FRAME_W(8)
  ) dut (
    .vga_clk(vga_clk), .reset(reset), .pix_ce(pix_ce),
    .HS(HS), .VS(VS), .blank_n(blank_n), .pixelX(pixelX), .pixelY(pixelY),
    .line_start(line_start), .frame_start(frame_start), .vblank_start(vblank_start),
    .frame_cnt(frame_cnt)
  );

  vga_timing_gen #(
    .H_ACTIVE(HACT), .H_FRONT(HFP), .H_SYNC(HSY), .H_BACK(HBK),
    .V_ACTIVE(VACT), .V_FRONT(VFP), .V_SYNC(VSY), .V_BACK(VBK),
    .HS_POL(1), .VS_POL(1), .PIPE_LAT(3), .COORD_W(11), .FRAME_W(8)
  ) dut_lat (
    .vga_clk(vga_clk), .reset(reset), .pix_ce(pix_ce),
    .HS(HS2), .VS(VS2), .blank_n(blank2), .pixelX(px2), .pixelY(py2),
    .line_start(ls2), .frame_start(fs2), .vblank_start(vbs2),
    .frame_cnt(fc2)
  );

  // reference model state
  int         m_h = 0, m_v = 0, m_f = 0;
  logic [2:0] m_d [3];
  logic       ce_div = 1'b0;
  logic       ce_ph  = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // driver: apply one clock of inputs, push the model's prediction, compare after the edge
  task automatic cycle(input logic rst, input logic ce);
    logic [EW-1:0] e, got;
    logic hs, vs, act, ls, fs, vbs;
    logic [10:0] px, py;
    logic [2:0] tail;
    reset  = rst;
    pix_ce = ce;
    if (rst) begin
      e = {1'b1, 1'b1, 1'b0, 11'd0, 11'd0, 3'b000, 8'd0, 3'b000};
      m_h = 0; m_v = 0; m_f = 0;
      for (int i = 0; i < 3; i++) m_d[i] = 3'b000;
    end else begin
      hs  = (m_h < HSY);
      vs  = (m_v < VSY);
      act = (m_h >= HSY + HBK) && (m_h < HSY + HBK + HACT) &&
            (m_v >= VSY + VBK) && (m_v < VSY + VBK + VACT);
      px  = act ? 11'(m_h - HSY - HBK) : 11'd0;
      py  = act ? 11'(m_v - VSY - VBK) : 11'd0;
      ls  = ce && act && (m_h == HSY + HBK);
      fs  = ls && (m_v == VSY + VBK);
      vbs = ce && (m_h == 0) && (m_v == VSY + VBK + VACT);
      tail = m_d[2];
      m_d[2] = m_d[1];
      m_d[1] = m_d[0];
      m_d[0] = {hs, vs, act};
      e = {!hs, !vs, act, px, py, ls, fs, vbs, 8'(m_f), tail[2], tail[1], tail[0]};
      if (ce) begin
        m_h++;
        if (m_h == HT) begin
          m_h = 0;
          m_v++;
          if (m_v == VT) begin
            m_v = 0;
            m_f++;
          end
        end
      end
    end
    exp_q.push_back(e);
    @(posedge vga_clk);
    #1;
    got = {HS, VS, blank_n, pixelX, pixelY, line_start, frame_start, vblank_start,
           frame_cnt, HS2, VS2, blank2};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL sb_empty actual=%h required=queued", got);
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        errors++;
        $display("FAIL sb h=%0d v=%0d actual=%h required=%h", m_h, m_v, got, e);
      end
    end
  endtask

  task automatic step();
    logic c;
    if (ce_div) begin
      ce_ph = !ce_ph;
      c = ce_ph;
    end else begin
      c = 1'b1;
    end
    cycle(1'b0, c);
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0: return line_start;
      1: return frame_start;
      2: return VS;
      3: return HS;
      4: return blank2;
      5: return blank_n;
      6: return HS2;
      default: return 1'b0;
    endcase
  endfunction

  task automatic count_until(input int sel, input logic val, input int limit, output int n);
    n = 0;
    while (sig(sel) !== val && n < limit) begin
      step();
      n++;
    end
  endtask

  task automatic measure_period(input int sel, output int p);
    int n;
    count_until(sel, 1'b1, 2000, n);
    step();
    count_until(sel, 1'b1, 2000, n);
    p = n + 1;
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0);
    ce_ph = 1'b0;
  endtask

  typedef struct {
    int          n;
    logic        hs, vs, bl;
    logic [10:0] px, py;
    logic        ls, fs, vbs;
  } vec_t;

  vec_t tbl[10];
  int pos, n, p;

  initial begin
    // probe table: n = v*HT + h counter position after reset, expected decode at that position
    tbl[0] = '{0,   0, 0, 0, 11'd0, 11'd0, 0, 0, 0};
    tbl[1] = '{18,  1, 0, 0, 11'd0, 11'd0, 0, 0, 0};
    tbl[2] = '{32,  0, 1, 0, 11'd0, 11'd0, 0, 0, 0};
    tbl[3] = '{50,  1, 1, 0, 11'd0, 11'd0, 0, 0, 0};
    tbl[4] = '{65,  1, 1, 1, 11'd0, 11'd0, 1, 1, 0};
    tbl[5] = '{72,  1, 1, 1, 11'd7, 11'd0, 0, 0, 0};
    tbl[6] = '{73,  1, 1, 0, 11'd0, 11'd0, 0, 0, 0};
    tbl[7] = '{80,  1, 1, 1, 11'd0, 11'd1, 1, 0, 0};
    tbl[8] = '{117, 1, 1, 1, 11'd7, 11'd3, 0, 0, 0};
    tbl[9] = '{120, 0, 1, 0, 11'd0, 11'd0, 0, 0, 1};

    do_reset();
    do_reset();
    chk("rst_hs", HS, 1);
    chk("rst_vs", VS, 1);
    chk("rst_blank", blank_n, 0);
    chk("rst_fcnt", frame_cnt, 0);
    chk("rst_hs_lat", HS2, 0);
    chk("rst_vs_lat", VS2, 0);

    pos = 0;
    for (int i = 0; i < 10; i++) begin
      while (pos < tbl[i].n) begin
        step();
        pos++;
      end
      step();
      pos++;
      chk($sformatf("tbl%0d_hs", i), HS, tbl[i].hs);
      chk($sformatf("tbl%0d_vs", i), VS, tbl[i].vs);
      chk($sformatf("tbl%0d_blank", i), blank_n, tbl[i].bl);
      chk($sformatf("tbl%0d_px", i), pixelX, tbl[i].px);
      chk($sformatf("tbl%0d_py", i), pixelY, tbl[i].py);
      chk($sformatf("tbl%0d_ls", i), line_start, tbl[i].ls);
      chk($sformatf("tbl%0d_fs", i), frame_start, tbl[i].fs);
      chk($sformatf("tbl%0d_vbs", i), vblank_start, tbl[i].vbs);
    end

    // line/frame periods and sync widths
    measure_period(0, p);
    chk("line_period", p, HT);
    measure_period(1, p);
    chk("frame_period", p, FT);
    count_until(3, 1'b0, 2000, n);
    count_until(3, 1'b1, 2000, n);
    chk("hs_low_len", n, HSY);
    count_until(3, 1'b0, 2000, n);
    chk("hs_high_len", n, HT - HSY);
    count_until(2, 1'b0, 2000, n);
    count_until(2, 1'b1, 2000, n);
    chk("vs_low_len", n, VSY * HT);

    // post-reset latency: base vs PIPE_LAT=3 copy
    do_reset();
    count_until(3, 1'b0, 2000, n);
    chk("hs_assert_lat0", n, 1);
    do_reset();
    count_until(6, 1'b1, 2000, n);
    chk("hs_assert_lat3", n, 4);
    do_reset();
    count_until(5, 1'b1, 2000, n);
    chk("blank_first", n, (VSY + VBK) * HT + HSY + HBK + 1);
    do_reset();
    count_until(4, 1'b1, 2000, n);
    chk("blank_first_lat3", n, (VSY + VBK) * HT + HSY + HBK + 4);

    // divided pixel enable
    do_reset();
    ce_div = 1'b1;
    measure_period(0, p);
    chk("line_period_div", p, 2 * HT);
    step();
    chk("ls_width_div", line_start, 0);
    measure_period(1, p);
    chk("frame_period_div", p, 2 * FT);
    step();
    chk("fs_width_div", frame_start, 0);
    ce_div = 1'b0;

    // frame counter wrap
    do_reset();
    for (int i = 0; i < 256 * FT; i++) step();
    chk("fcnt_255", frame_cnt, 255);
    step();
    chk("fcnt_wrap0", frame_cnt, 0);
    for (int i = 0; i < FT; i++) step();
    chk("fcnt_1", frame_cnt, 1);

    // mid-line reset at h=10, v=5 (counter currently at h=1, v=0)
    for (int i = 0; i < 5 * HT + 10 - 1; i++) step();
    chk("pre_rst_blank", blank_n, 1);
    cycle(1'b1, 1'b1);
    chk("mid_rst_hs", HS, 1);
    chk("mid_rst_blank", blank_n, 0);
    chk("mid_rst_px", pixelX, 0);
    chk("mid_rst_fcnt", frame_cnt, 0);
    chk("mid_rst_blank_lat", blank2, 0);
    count_until(4, 1'b1, 2000, n);
    chk("post_rst_blank_lat3", n, (VSY + VBK) * HT + HSY + HBK + 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
